// File: rtl/timer_bank_if.sv
// timer_bank_if: control/status bundle between a timer_bank and its host.
// The host drives the master side; the timer bank sits on the slave side.
interface timer_bank_if #(
    parameter int Bit = 32,
    parameter int Ch = 4
);
    logic              Enable;
    logic [Ch-1:0]     Start;
    logic [Ch-1:0]     Dir;
    logic [2*Ch-1:0]   Mode;
    logic [Ch-1:0]     Load;
    logic [Ch*Bit-1:0] LoadVal;
    logic [Ch*Bit-1:0] Period;
    logic [Ch*Bit-1:0] Compare;
    logic [Ch-1:0]     Capture;
    logic [Ch*Bit-1:0] Dout;
    logic [Ch*Bit-1:0] CapVal;
    logic [Ch-1:0]     Match;
    logic [Ch-1:0]     Wrap;
    logic [Ch-1:0]     Busy;

    modport master (
        output Enable, Start, Dir, Mode, Load, LoadVal, Period, Compare, Capture,
        input  Dout, CapVal, Match, Wrap, Busy
    );

    modport slave (
        input  Enable, Start, Dir, Mode, Load, LoadVal, Period, Compare, Capture,
        output Dout, CapVal, Match, Wrap, Busy
    );
endinterface

// File: rtl/timer_bank.sv
// timer_bank: Ch independent Bit-wide up/down timers (FREE/PERIOD/ONESHOT/HOLD) with match/wrap pulses.
// Define TIMER_BANK_CAPTURE_EN to add per-channel rising-edge capture into CapVal.
module timer_bank #(
    parameter int Bit = 32,
    parameter int Ch = 4
) (
    input logic Clk,
    input logic Clr,
    timer_bank_if.slave bus
);
    typedef enum logic [1:0] {
        FREE    = 2'b00,
        PERIOD  = 2'b01,
        ONESHOT = 2'b10,
        HOLD    = 2'b11
    } mode_e;

    localparam logic [Bit-1:0] SMAX = {1'b0, {(Bit-1){1'b1}}};
    localparam logic [Bit-1:0] SMIN = {1'b1, {(Bit-1){1'b0}}};
    localparam logic [Bit-1:0] ONE  = Bit'(1);

    for (genvar i = 0; i < Ch; i++) begin : g_ch
        mode_e          md;
        logic [Bit-1:0] cnt, per, cmp, inc, nxt;
        logic           up, go, done, term, free_wr, per_wr, wr;
        logic           match, wrap, busy;

        assign md  = mode_e'(bus.Mode[2*i +: 2]);
        assign up  = bus.Dir[i];
        assign per = bus.Period[i*Bit +: Bit];
        assign cmp = bus.Compare[i*Bit +: Bit];
        assign go  = bus.Enable & bus.Start[i] & ~done & (md != HOLD);

        // FREE wraps symmetrically (never lands on the opposite extreme); PERIOD/ONESHOT are unsigned
        always_comb begin
            inc     = up ? cnt + ONE : cnt - ONE;
            free_wr = up ? cnt == SMAX : cnt == SMIN;
            per_wr  = up ? cnt >= per : (cnt == '0 || cnt > per);
            term    = md == ONESHOT && (up ? cnt >= per : cnt == '0);
            wr      = md == FREE ? free_wr : per_wr;
            nxt     = term ? cnt :
                      md == FREE ? (free_wr ? (up ? ONE : '1) : inc) :
                      per_wr ? (up ? '0 : per) : inc;
        end

        always_ff @(posedge Clk) begin
            if (Clr) begin
                cnt   <= '0;
                done  <= 1'b0;
                match <= 1'b0;
                wrap  <= 1'b0;
                busy  <= 1'b0;
            end else begin
                busy <= go;
                if (bus.Load[i]) begin
                    cnt   <= bus.LoadVal[i*Bit +: Bit];
                    done  <= 1'b0;
                    match <= 1'b0;
                    wrap  <= 1'b0;
                end else begin
                    match <= go && nxt == cmp;
                    wrap  <= go && wr;
                    if (go) cnt <= nxt;
                    if (go && term) done <= 1'b1;
                end
            end
        end

        assign bus.Dout[i*Bit +: Bit] = cnt;
        assign bus.Match[i] = match;
        assign bus.Wrap[i]  = wrap;
        assign bus.Busy[i]  = busy;

`ifdef TIMER_BANK_CAPTURE_EN
        logic           cap_prev;
        logic [Bit-1:0] cap;

        // cnt is the pre-update value, so a same-cycle Load still captures the old count
        always_ff @(posedge Clk) begin
            if (Clr) begin
                cap_prev <= 1'b0;
                cap      <= '0;
            end else begin
                cap_prev <= bus.Capture[i];
                if (bus.Capture[i] && !cap_prev) cap <= cnt;
            end
        end

        assign bus.CapVal[i*Bit +: Bit] = cap;
`else
        assign bus.CapVal[i*Bit +: Bit] = '0;
`endif
    end

`ifndef TIMER_BANK_CAPTURE_EN
    logic unused_capture;
    assign unused_capture = ^bus.Capture;
`endif
endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed checks of timer_bank (Bit=8, Ch=4) with hand-computed expectations.
module tb_timer_bank;
    localparam logic [1:0] FREE = 2'b00, PERIOD = 2'b01, ONESHOT = 2'b10;

    logic Clk = 1'b0;
    logic Clr;
    int   checks = 0;
    int   failures = 0;

    timer_bank_if #(.Bit(8), .Ch(4)) bus ();
    timer_bank #(.Bit(8), .Ch(4)) dut (.Clk(Clk), .Clr(Clr), .bus(bus));

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [7:0] dv(int i);
        return bus.Dout[i*8 +: 8];
    endfunction

    function automatic logic [7:0] cv(int i);
        return bus.CapVal[i*8 +: 8];
    endfunction

    task automatic cfg(int i, logic st, logic dr, logic [1:0] md, logic [7:0] per, logic [7:0] cmp);
        bus.Start[i] = st;
        bus.Dir[i] = dr;
        bus.Mode[2*i +: 2] = md;
        bus.Period[i*8 +: 8] = per;
        bus.Compare[i*8 +: 8] = cmp;
    endtask

    task automatic load(int i, logic [7:0] v);
        bus.Load[i] = 1'b1;
        bus.LoadVal[i*8 +: 8] = v;
        tick();
        bus.Load[i] = 1'b0;
    endtask

    task automatic test_reset();
        Clr = 1'b1;
        bus.Enable = 1'b1;
        bus.Start = '1;
        bus.Dir = '1;
        bus.Mode = '0;
        bus.Load = '0;
        bus.LoadVal = '0;
        bus.Period = '0;
        bus.Compare = '1;
        bus.Capture = '0;
        tick();
        tick();
        checks++; if (bus.Dout !== '0) begin failures++; $display("FAIL reset_dout got=%h exp=0", bus.Dout); end
        checks++; if (bus.Match !== '0) begin failures++; $display("FAIL reset_match got=%b exp=0", bus.Match); end
        checks++; if (bus.Wrap !== '0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", bus.Wrap); end
        checks++; if (bus.Busy !== '0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.Busy); end
        checks++; if (bus.CapVal !== '0) begin failures++; $display("FAIL reset_capval got=%h exp=0", bus.CapVal); end
        bus.Start = '0;
        bus.Enable = 1'b0;
        Clr = 1'b0;
    endtask

    task automatic test_free();
        logic [7:0] ed [3] = '{8'd127, 8'd1, 8'd2};
        logic       ew [3] = '{1'b0, 1'b1, 1'b0};
        cfg(0, 1'b0, 1'b1, FREE, 8'd0, 8'h55);
        bus.Enable = 1'b1;
        load(0, 8'd126);
        checks++; if (dv(0) !== 8'd126) begin failures++; $display("FAIL free_load got=%0d exp=126", dv(0)); end
        bus.Start[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (dv(0) !== ed[k] || bus.Wrap[0] !== ew[k]) begin
                failures++; $display("FAIL free_up[%0d] got=%0d/w%b exp=%0d/w%b", k, dv(0), bus.Wrap[0], ed[k], ew[k]);
            end
        end
        checks++; if (bus.Busy[0] !== 1'b1) begin failures++; $display("FAIL free_busy got=%b exp=1", bus.Busy[0]); end
        bus.Dir[0] = 1'b0;
        load(0, 8'h80);
        checks++; if (dv(0) !== 8'h80 || bus.Wrap[0] !== 1'b0) begin failures++; $display("FAIL free_load_min got=%h/w%b exp=80/w0", dv(0), bus.Wrap[0]); end
        tick();
        checks++; if (dv(0) !== 8'hFF || bus.Wrap[0] !== 1'b1) begin failures++; $display("FAIL free_down_wrap got=%h/w%b exp=ff/w1", dv(0), bus.Wrap[0]); end
        tick();
        checks++; if (dv(0) !== 8'hFE || bus.Wrap[0] !== 1'b0) begin failures++; $display("FAIL free_down_step got=%h/w%b exp=fe/w0", dv(0), bus.Wrap[0]); end
        bus.Start[0] = 1'b0;
    endtask

    task automatic test_period();
        logic [7:0] ed [7] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1};
        logic       em [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       ew [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        cfg(1, 1'b0, 1'b1, PERIOD, 8'd5, 8'd3);
        load(1, 8'd0);
        bus.Start[1] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            checks++; if (dv(1) !== ed[k] || bus.Match[1] !== em[k] || bus.Wrap[1] !== ew[k]) begin
                failures++; $display("FAIL period_up[%0d] got=%0d/m%b/w%b exp=%0d/m%b/w%b", k, dv(1), bus.Match[1], bus.Wrap[1], ed[k], em[k], ew[k]);
            end
        end
        bus.Start[1] = 1'b0;
        bus.Dir[1] = 1'b0;
        load(1, 8'd0);
        bus.Start[1] = 1'b1;
        tick();
        checks++; if (dv(1) !== 8'd5 || bus.Wrap[1] !== 1'b1) begin failures++; $display("FAIL period_down_reload got=%0d/w%b exp=5/w1", dv(1), bus.Wrap[1]); end
        tick();
        checks++; if (dv(1) !== 8'd4 || bus.Wrap[1] !== 1'b0) begin failures++; $display("FAIL period_down_step got=%0d/w%b exp=4/w0", dv(1), bus.Wrap[1]); end
        cfg(1, 1'b1, 1'b1, PERIOD, 8'd0, 8'd9);
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (dv(1) !== 8'd0 || bus.Wrap[1] !== 1'b1) begin
                failures++; $display("FAIL period_zero[%0d] got=%0d/w%b exp=0/w1", k, dv(1), bus.Wrap[1]);
            end
        end
        bus.Start[1] = 1'b0;
    endtask

    task automatic test_oneshot();
        logic [7:0] ed [6] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 8'd4};
        logic       ew [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       eb [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        cfg(2, 1'b0, 1'b1, ONESHOT, 8'd4, 8'd9);
        load(2, 8'd0);
        bus.Start[2] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++; if (dv(2) !== ed[k] || bus.Wrap[2] !== ew[k] || bus.Busy[2] !== eb[k]) begin
                failures++; $display("FAIL oneshot[%0d] got=%0d/w%b/b%b exp=%0d/w%b/b%b", k, dv(2), bus.Wrap[2], bus.Busy[2], ed[k], ew[k], eb[k]);
            end
        end
        load(2, 8'd0);
        checks++; if (dv(2) !== 8'd0) begin failures++; $display("FAIL oneshot_rearm_load got=%0d exp=0", dv(2)); end
        tick();
        checks++; if (dv(2) !== 8'd1 || bus.Busy[2] !== 1'b1) begin failures++; $display("FAIL oneshot_resume got=%0d/b%b exp=1/b1", dv(2), bus.Busy[2]); end
        bus.Start[2] = 1'b0;
    endtask

    task automatic test_priority();
        logic [31:0] snap;
        cfg(3, 1'b1, 1'b1, FREE, 8'd0, 8'hEE);
        bus.Enable = 1'b1;
        load(3, 8'd50);
        checks++; if (dv(3) !== 8'd50) begin failures++; $display("FAIL load_over_step got=%0d exp=50", dv(3)); end
        tick();
        checks++; if (dv(3) !== 8'd51) begin failures++; $display("FAIL step_after_load got=%0d exp=51", dv(3)); end
        bus.Enable = 1'b0;
        bus.Start = '1;
        snap = bus.Dout;
        tick();
        tick();
        checks++; if (bus.Dout !== snap) begin failures++; $display("FAIL enable_freeze got=%h exp=%h", bus.Dout, snap); end
        checks++; if (bus.Busy !== 4'b0000) begin failures++; $display("FAIL enable_busy got=%b exp=0000", bus.Busy); end
        bus.Start = 4'b0010;
        cfg(1, 1'b1, 1'b1, FREE, 8'd0, 8'hEE);
        load(1, 8'd10);
        checks++; if (dv(1) !== 8'd10) begin failures++; $display("FAIL load_no_enable got=%0d exp=10", dv(1)); end
        bus.Enable = 1'b1;
        snap = bus.Dout;
        tick();
        tick();
        checks++; if (dv(1) !== 8'd12) begin failures++; $display("FAIL start1_runs got=%0d exp=12", dv(1)); end
        checks++; if (dv(0) !== snap[7:0] || dv(2) !== snap[23:16] || dv(3) !== snap[31:24]) begin
            failures++; $display("FAIL start1_others got=%h exp=%h (ch1 excluded)", bus.Dout, snap);
        end
        checks++; if (bus.Busy !== 4'b0010) begin failures++; $display("FAIL start1_busy got=%b exp=0010", bus.Busy); end
    endtask

    task automatic test_clr_mid();
        bus.Start = '1;
        bus.Enable = 1'b1;
        tick();
        Clr = 1'b1;
        bus.Load[0] = 1'b1;
        bus.LoadVal[7:0] = 8'd99;
        bus.Capture = '1;
        tick();
        checks++; if (bus.Dout !== '0 || bus.Busy !== '0 || bus.Match !== '0 || bus.Wrap !== '0 || bus.CapVal !== '0) begin
            failures++; $display("FAIL clr_mid got=%h/b%b/m%b/w%b/c%h exp=all zero", bus.Dout, bus.Busy, bus.Match, bus.Wrap, bus.CapVal);
        end
        Clr = 1'b0;
        bus.Load = '0;
        bus.Capture = '0;
        bus.Start = '0;
        tick();
    endtask

    task automatic test_capture();
        cfg(2, 1'b0, 1'b1, FREE, 8'd0, 8'hEE);
        load(2, 8'd37);
`ifdef TIMER_BANK_CAPTURE_EN
        bus.Capture[2] = 1'b1;
        tick();
        checks++; if (cv(2) !== 8'd37) begin failures++; $display("FAIL cap_edge got=%0d exp=37", cv(2)); end
        load(2, 8'd40);
        tick();
        checks++; if (cv(2) !== 8'd37) begin failures++; $display("FAIL cap_no_edge got=%0d exp=37", cv(2)); end
        bus.Capture[2] = 1'b0;
        tick();
        bus.Capture[2] = 1'b1;
        load(2, 8'd60);
        checks++; if (cv(2) !== 8'd40 || dv(2) !== 8'd60) begin failures++; $display("FAIL cap_with_load got=%0d/d%0d exp=40/d60", cv(2), dv(2)); end
`else
        for (int k = 0; k < 4; k++) begin
            bus.Capture = (k % 2 == 0) ? 4'b1111 : 4'b0000;
            tick();
            checks++; if (bus.CapVal !== '0) begin failures++; $display("FAIL cap_disabled[%0d] got=%h exp=0", k, bus.CapVal); end
        end
`endif
        bus.Capture = '0;
    endtask

    initial begin
        test_reset();
        test_free();
        test_period();
        test_oneshot();
        test_priority();
        test_clr_mid();
        test_capture();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/timer_bank.md
# timer_bank

Multi-channel, parametrised successor to the single up/down timer. Provides `Ch` independent counters of `Bit` width, each with its own start/direction/mode and load, compare and period registers. Every channel supports free-running symmetric wrap, periodic reload and one-shot operation, with registered match and wrap event pulses. It sits in the motor/encoder timing path as the shared timebase and event source for PWM and odometry logic.

## Interface
- `Bit`, 32: counter width per channel (≥4)
- `Ch`, 4: number of channels (1–16)
- `Clk` input 1: clock, all logic on rising edge
- `Clr` input 1: synchronous, active-high reset
- `Enable` input 1: global count enable, gates all channels
- `Start` input Ch: per-channel run enable
- `Dir` input Ch: 1 = count up, 0 = count down
- `Mode` input 2*Ch: channel i at [2i+1:2i]; 00 FREE, 01 PERIOD, 10 ONESHOT, 11 HOLD
- `Load` input Ch: load strobe; channel i loads its `LoadVal` slice
- `LoadVal` input Ch*Bit: load values, channel i at [i*Bit +: Bit]
- `Period` input Ch*Bit: terminal values (PERIOD/ONESHOT), unsigned
- `Compare` input Ch*Bit: match values
- `Capture` input Ch: capture trigger (capture feature only)
- `Dout` output Ch*Bit: counter values
- `CapVal` output Ch*Bit: captured values
- `Match` output Ch: 1-cycle pulse, counter stepped onto `Compare`
- `Wrap` output Ch: 1-cycle pulse on wrap/reload/terminal event
- `Busy` output Ch: channel actively counting

## Operation
- Priority per channel per cycle: `Clr` > `Load` > step > hold.
- `Clr`: `Dout`, `CapVal`, `Match`, `Wrap` = 0; all done flags cleared; `Busy` = 0.
- `Load[i]`: `Dout_i` <= `LoadVal_i`; clears done_i; `Match`/`Wrap` = 0 that cycle. Independent of `Enable`/`Start`.
- Step occurs when `Enable & Start[i] & ~done_i` and mode ≠ HOLD; `Busy[i]` equals this condition.
- FREE (signed, backward-compatible):
  - up: if `Dout` == 2^(Bit-1)-1 then `Dout` <= 1 and `Wrap`; else +1.
  - down: if `Dout` == -2^(Bit-1) then `Dout` <= -1 and `Wrap`; else -1.
- PERIOD (unsigned):
  - up: if `Dout` ≥ `Period` then `Dout` <= 0 and `Wrap`; else +1.
  - down: if `Dout` == 0 or `Dout` > `Period` then `Dout` <= `Period` and `Wrap`; else -1.
- ONESHOT: same step as PERIOD up to the terminal. When the terminal is reached (up: `Dout` ≥ `Period`; down: `Dout` == 0), `Dout` holds at the terminal value, `Wrap` pulses once and done_i sets. Only `Load` or `Clr` re-arms.
- HOLD: `Dout` frozen, no events.
- `Match[i]` = 1 in the cycle after a step whose new value equals `Compare_i`. Loads never raise `Match`.
- `Period` == 0 in PERIOD mode: `Dout` stays 0 and `Wrap` pulses every stepping cycle.
- Mode/`Dir` changes take effect on the next step; `Dout` is not altered by the change.

## Timing
- All outputs registered; step/load/clear visible on `Dout` one cycle after the qualifying edge.
- `Match`/`Wrap` are aligned with the `Dout` value that caused them and are high exactly one cycle per event.
- `Busy` is registered from the same-cycle conditions, with one cycle of latency.
- `Clr` mid-count or mid-oneshot: next cycle all outputs are 0, regardless of other inputs.
- `Load` and `Capture` in the same cycle: capture records the pre-load `Dout`.

## Configuration
- `TIMER_BANK_CAPTURE_EN` defined:
  - Each channel registers `Capture` and detects rising edges (previous-sample register, reset 0).
  - On an edge, `CapVal_i` <= current `Dout_i`, giving 1-cycle latency from the registered edge.
- Undefined: capture logic is removed, `CapVal` is constant 0 and `Capture` is ignored.

## Test plan
- Reset: drive `Clr` = 1 for 2 cycles with `Start` = all 1 -> all `Dout`/`Match`/`Wrap`/`Busy`/`CapVal` = 0.
- FREE wrap: Bit = 8, Load 126, up, run -> 127, then 1 with `Wrap` = 1 for one cycle. Load -128, down -> -1 with `Wrap`.
- PERIOD: `Period` = 5, `Compare` = 3, up from 0 -> 0,1,2,3 (`Match`),4,5,0 (`Wrap`). Down from 0 -> 5 with `Wrap`, then 4. `Period` = 0 -> `Wrap` every cycle.
- ONESHOT: `Period` = 4, up from 0 -> stops at 4, single `Wrap`, `Busy` = 0. `Load` 0 -> counting resumes.
- Priority and independence: `Load` and step in the same cycle -> `LoadVal` wins. `Enable` = 0 freezes all channels. `Start[1]` only -> channels 0, 2 and 3 hold.
- Capture (macro on): rising edge on `Capture[2]` while `Dout_2` = 37 -> `CapVal_2` = 37. No change without an edge. Macro off -> `CapVal` stays 0.
